ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers in the EX stage.
- Consumes the ID/EX pipeline register outputs: operands ReadData1/ReadData2 and the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO function.
- Holds the architectural HI/LO pair, read by MFHI/MFLO via the forwarding path.
- Raises Busy so the hazard unit stalls IF/ID and bubbles ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous active-high reset.
- Start  in  1  launch the operation selected by Op (from ID_EX control).
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- OperandA  in  WIDTH  rs value (ID_EX_ReadData1 after forwarding).
- OperandB  in  WIDTH  rt value (ID_EX_ReadData2 after forwarding).
- HiWrite  in  1  MTHI strobe.
- LoWrite  in  1  MTLO strobe.
- WriteData  in  WIDTH  MTHI/MTLO data.
- Cancel  in  1  abort the in-flight operation (branch/jump flush).
- Busy  out  1  operation in progress; drives the stall.
- Done  out  1  one-cycle pulse when HI/LO take a new result.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset: Rst=1 at an edge forces state IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter=0, and clears internal datapath registers. Rst overrides every other input, including mid-operation.
- States:
  - IDLE: Start=1 latches operand magnitudes (absolute values for signed ops), the result signs (quotient sign = signA^signB, remainder/HI sign = signA; product sign = signA^signB), Op, and counter=0; goes to RUN.
  - RUN: performs one radix-2 step per edge. Multiply is shift-add; divide is restoring shift-subtract. After WIDTH steps it goes to FINISH.
  - FINISH: applies sign correction and writes Hi/Lo at that edge; goes to IDLE.
- Timing: Start sampled at edge E0.
  - Busy=1 in the cycles after E0 through E32.
  - Hi/Lo are updated at E33. Done=1 for exactly the cycle after E33, with Busy=0 in that cycle.
  - Start to Done is 34 cycles.
- Results:
  - MULT/MULTU: {Hi,Lo} = 64-bit product.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
- Divide by zero: Lo = all ones, Hi = original dividend (raw OperandA, signed or not). Still takes the full 34 cycles.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0, with no exception.
- Start while Busy=1 is ignored. The hazard unit guarantees no such Start; the bench checks that it is ignored.
- HiWrite/LoWrite:
  - In IDLE they write Hi/Lo at the next edge, and both may write in the same cycle.
  - While Busy=1 they are ignored.
  - In the same cycle as a Start, the MTHI/MTLO write applies first, and the later result overwrites it.
- Cancel:
  - Cancel=1 while Busy=1: goes to IDLE at the next edge. Hi/Lo stay unchanged, no Done, Busy=0 in the following cycle.
  - Cancel with Start in IDLE: the Start is dropped.
  - Cancel in IDLE without Start: no effect.
- Hi/Lo change only on reset, MTHI/MTLO, or FINISH.

Optional Feature:
- Macro: MULDIV_FASTMUL_EN.
- Defined: MULT/MULTU complete in a single cycle using a combinational WIDTH x WIDTH product.
  - Start at E0 writes Hi/Lo at E1, and Done=1 in the cycle after E1.
  - Busy is never asserted for multiply.
  - Divide keeps the iterative 34-cycle timing.
- Undefined: multiply uses the iterative path and the timing described in Behaviour.

Test Plan:
- Rst, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 34 cycles Hi=0xFFFFFFFE, Lo=0x00000001, Done pulses once, Busy high 33 cycles (fast mode: Done after 1 cycle, Busy never high).
- MULT A=0xFFFFFFFD(-3) B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIV A=0xFFFFFFF9(-7) B=2 -> Lo=0xFFFFFFFD(-3), Hi=0xFFFFFFFF(-1); DIVU A=100 B=7 -> Lo=14, Hi=2.
- DIV A=0x80000000 B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; DIVU A=5 B=0 -> Lo=0xFFFFFFFF, Hi=5.
- MTLO 0x1234 then DIVU start, Cancel at cycle 10 -> Busy=0 the next cycle, no Done, Lo stays 0x1234; HiWrite during Busy leaves Hi unchanged.
- Rst asserted at cycle 20 of a MULT -> all outputs 0 the next cycle; a new DIVU 9/3 then completes normally with Lo=3, Hi=0.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : Operation, MTHI/MTLO and result bundle for the EX-stage
//               multiply/divide unit.
// Revision    : 1.0
// ============================================================================
interface ex_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic             HiWrite;
   logic             LoWrite;
   logic [WIDTH-1:0] WriteData;
   logic             Cancel;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData, Cancel,
      input  Busy, Done, Hi, Lo
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData, Cancel,
      output Busy, Done, Hi, Lo
   );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative radix-2 multiply/divide with HI/LO registers.
//               Define MULDIV_FASTMUL_EN for single-cycle multiply.
// Revision    : 1.0
// ============================================================================
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic         Clk,
   input  wire logic         Rst,
   ex_muldiv_unit_if.slave   bus
);
   localparam int c_CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_count;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_is_div;
   logic               r_sign_q;
   logic               r_sign_r;
   logic               r_div0;
   logic [WIDTH-1:0]   r_raw_a;
   logic [WIDTH-1:0]   r_mag_b;
   logic [WIDTH-1:0]   r_hi_acc;
   logic [WIDTH-1:0]   r_lo_acc;

   logic               w_sa;
   logic               w_sb;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shift;
   logic               w_fits;
   logic [WIDTH-1:0]   w_rem_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   // Op[0]=0 selects the signed variants (MULT, DIV)
   assign w_sa    = ~bus.Op[0] & bus.OperandA[WIDTH-1];
   assign w_sb    = ~bus.Op[0] & bus.OperandB[WIDTH-1];
   assign w_mag_a = w_sa ? -bus.OperandA : bus.OperandA;
   assign w_mag_b = w_sb ? -bus.OperandB : bus.OperandB;

   assign w_sum      = {1'b0, r_hi_acc} + {1'b0, (r_lo_acc[0] ? r_mag_b : {WIDTH{1'b0}})};
   assign w_shift    = {r_hi_acc, r_lo_acc[WIDTH-1]};
   assign w_fits     = (w_shift >= {1'b0, r_mag_b});
   // True difference is below the divisor, so the low WIDTH bits are exact
   assign w_rem_next = w_shift[WIDTH-1:0] - r_mag_b;

   assign w_prod     = {r_hi_acc, r_lo_acc};
   assign w_prod_fix = r_sign_q ? -w_prod : w_prod;
   assign w_quot     = r_sign_q ? -r_lo_acc : r_lo_acc;
   assign w_rem      = r_sign_r ? -r_hi_acc : r_hi_acc;

`ifdef MULDIV_FASTMUL_EN
   logic [2*WIDTH-1:0] w_fast_prod;
   assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_div0   <= 1'b0;
         r_raw_a  <= '0;
         r_mag_b  <= '0;
         r_hi_acc <= '0;
         r_lo_acc <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.HiWrite) r_hi <= bus.WriteData;
               if (bus.LoWrite) r_lo <= bus.WriteData;
               if (bus.Start && !bus.Cancel) begin
                  r_is_div <= bus.Op[1];
                  r_sign_q <= w_sa ^ w_sb;
                  r_sign_r <= w_sa;
                  r_div0   <= bus.Op[1] && (bus.OperandB == '0);
                  r_raw_a  <= bus.OperandA;
                  r_mag_b  <= w_mag_b;
                  r_hi_acc <= '0;
                  r_lo_acc <= w_mag_a;
                  r_count  <= '0;
                  r_state  <= S_RUN;
                  r_busy   <= 1'b1;
`ifdef MULDIV_FASTMUL_EN
                  if (!bus.Op[1]) begin
                     r_hi_acc <= w_fast_prod[2*WIDTH-1:WIDTH];
                     r_lo_acc <= w_fast_prod[WIDTH-1:0];
                     r_state  <= S_FINISH;
                     r_busy   <= 1'b0;
                  end
`endif
               end
            end
            S_RUN: begin
               if (bus.Cancel) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_is_div) begin
                     r_hi_acc <= w_fits ? w_rem_next : w_shift[WIDTH-1:0];
                     r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_fits};
                  end else begin
                     r_hi_acc <= w_sum[WIDTH:1];
                     r_lo_acc <= {w_sum[0], r_lo_acc[WIDTH-1:1]};
                  end
                  r_count <= r_count + c_CNT_W'(1);
                  if (r_count == c_CNT_W'(WIDTH-1)) r_state <= S_FINISH;
               end
            end
            S_FINISH: begin
               // A fast multiply sits here with Busy low and cannot be cancelled
               if (bus.Cancel && r_busy) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_is_div) begin
                     if (r_div0) begin
                        r_hi <= r_raw_a;
                        r_lo <= '1;
                     end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                     end
                  end else begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy = r_busy;
   assign bus.Done = r_done;
   assign bus.Hi   = r_hi;
   assign bus.Lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Directed and random checks of ex_muldiv_unit against an
//               arithmetic reference model.
// Revision    : 1.0
// ============================================================================
module tb_ex_muldiv_unit;
   localparam int WIDTH = 32;
   localparam int c_WIN = 40;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ex_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
   ex_muldiv_unit #(.WIDTH(WIDTH)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Result as {HI, LO} from plain arithmetic
   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint    sa, sb, q, r;
      logic [31:0] uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: return 64'(sa * sb);
         2'd1: return {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
      endcase
   endfunction

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start    = 1'b1;
      bus.Op       = op;
      bus.OperandA = a;
      bus.OperandB = b;
      tick();
      bus.Start    = 1'b0;
      bus.HiWrite  = 1'b0;
      bus.LoWrite  = 1'b0;
   endtask

   // Samples from index i0 (current sample) to the end of the window
   task automatic watch(input int i0, output int first, output int ndone, output int nbusy);
      first = -1;
      ndone = 0;
      nbusy = 0;
      for (int i = i0; i < c_WIN; i++) begin
         if (i > i0) tick();
         if (bus.Busy) nbusy++;
         if (bus.Done) begin
            ndone++;
            if (first < 0) first = i;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      int first, ndone, nbusy, lat, busy_exp;
      logic [63:0] exp;
      exp = ref_model(op, a, b);
      lat = 33;
      busy_exp = 33;
`ifdef MULDIV_FASTMUL_EN
      if (!op[1]) begin
         lat = 1;
         busy_exp = 0;
      end
`endif
      start_op(op, a, b);
      watch(0, first, ndone, nbusy);
      chk({tag, ".latency"}, first, lat);
      chk({tag, ".done_cnt"}, ndone, 1);
      chk({tag, ".busy_cnt"}, nbusy, busy_exp);
      chk({tag, ".hi"}, bus.Hi, exp[63:32]);
      chk({tag, ".lo"}, bus.Lo, exp[31:0]);
   endtask

   initial begin
      int first, ndone, nbusy;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      bus.Start = 0; bus.Op = 0; bus.OperandA = 0; bus.OperandB = 0;
      bus.HiWrite = 0; bus.LoWrite = 0; bus.WriteData = 0; bus.Cancel = 0;
      Rst = 1'b1;
      tick();
      tick();
      chk("reset.busy", bus.Busy, 0);
      chk("reset.done", bus.Done, 0);
      chk("reset.hi", bus.Hi, 0);
      chk("reset.lo", bus.Lo, 0);
      Rst = 1'b0;
      tick();

      do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max.hi_const", bus.Hi, 32'hFFFF_FFFE);
      chk("multu_max.lo_const", bus.Lo, 32'h0000_0001);
      do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
      do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg.lo_const", bus.Lo, 32'hFFFF_FFFD);
      do_op("divu", 2'd3, 32'd100, 32'd7);
      do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf.lo_const", bus.Lo, 32'h8000_0000);
      do_op("divu_zero", 2'd3, 32'd5, 32'd0);
      do_op("div_zero", 2'd2, 32'hFFFF_FF00, 32'd0);

      for (int k = 0; k < 12; k++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         do_op("random", rop, ra, rb);
      end

      // MTHI and MTLO together, then MTHI alone
      bus.HiWrite = 1; bus.LoWrite = 1; bus.WriteData = 32'h1234;
      tick();
      bus.LoWrite = 0; bus.WriteData = 32'h5678;
      tick();
      bus.HiWrite = 0;
      chk("mtlo.lo", bus.Lo, 32'h1234);
      chk("mthi.hi", bus.Hi, 32'h5678);

      // MTHI while busy is ignored; Cancel at cycle 10 aborts quietly
      start_op(2'd3, 32'd100, 32'd7);
      chk("cancel.busy_on", bus.Busy, 1);
      repeat (3) tick();
      bus.HiWrite = 1; bus.WriteData = 32'hDEAD;
      tick();
      bus.HiWrite = 0;
      chk("busy_mthi.hi", bus.Hi, 32'h5678);
      repeat (5) tick();
      bus.Cancel = 1;
      tick();
      bus.Cancel = 0;
      chk("cancel.busy_off", bus.Busy, 0);
      watch(10, first, ndone, nbusy);
      chk("cancel.no_done", ndone, 0);
      chk("cancel.lo", bus.Lo, 32'h1234);
      chk("cancel.hi", bus.Hi, 32'h5678);

      // Cancel together with Start in IDLE drops the Start
      bus.Cancel = 1;
      start_op(2'd2, 32'd50, 32'd5);
      bus.Cancel = 0;
      watch(0, first, ndone, nbusy);
      chk("idle_cancel.busy", nbusy, 0);
      chk("idle_cancel.done", ndone, 0);
      chk("idle_cancel.lo", bus.Lo, 32'h1234);

      // Start while busy is ignored
      start_op(2'd3, 32'd100, 32'd7);
      repeat (4) tick();
      bus.Start = 1; bus.Op = 2'd1; bus.OperandA = 3; bus.OperandB = 3;
      tick();
      bus.Start = 0;
      watch(5, first, ndone, nbusy);
      chk("restart.latency", first, 33);
      chk("restart.done_cnt", ndone, 1);
      chk("restart.hi", bus.Hi, 32'd2);
      chk("restart.lo", bus.Lo, 32'd14);

      // MTHI/MTLO in the Start cycle land first, then the result overwrites
      bus.HiWrite = 1; bus.LoWrite = 1; bus.WriteData = 32'hAAAA;
      start_op(2'd3, 32'd9, 32'd3);
      chk("mt_start.hi_early", bus.Hi, 32'hAAAA);
      watch(0, first, ndone, nbusy);
      chk("mt_start.done_cnt", ndone, 1);
      chk("mt_start.hi", bus.Hi, 32'd0);
      chk("mt_start.lo", bus.Lo, 32'd3);

      // Reset in the middle of a MULT
      start_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (19) tick();
      Rst = 1;
      tick();
      Rst = 0;
      chk("midrst.busy", bus.Busy, 0);
      chk("midrst.done", bus.Done, 0);
      chk("midrst.hi", bus.Hi, 0);
      chk("midrst.lo", bus.Lo, 0);
      do_op("post_rst_divu", 2'd3, 32'd9, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
